// File: rtl/mips_encode_pkg.sv
// Shared MIPS encode/decode constants: ALU op codes, opcodes, funct codes.
// Also holds the FIFO entry type used by the encoder.
package mips_encode_pkg;

    localparam logic [2:0] ALU_ADD = 3'd2;
    localparam logic [2:0] ALU_SUB = 3'd3;
    localparam logic [2:0] ALU_AND = 3'd4;
    localparam logic [2:0] ALU_OR  = 3'd5;
    localparam logic [2:0] ALU_NOR = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    typedef enum logic [1:0] {
        SRC2_REG  = 2'b00,
        SRC2_SEXT = 2'b01,
        SRC2_ZEXT = 2'b10,
        SRC2_RSVD = 2'b11
    } alu_src2_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        except;
    } enc_t;

endpackage

// File: rtl/mips_encode_fields.sv
// Combinational field-to-word mapping for the MIPS encoder.
// Unencodable requests yield inst=0 with except set.
module mips_encode_fields
    import mips_encode_pkg::*;
(
    input  logic [2:0]  alu_op,
    input  logic [1:0]  alu_src2,
    input  logic        rd_src,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] inst,
    output logic        except
);

    logic [5:0] funct;
    logic [5:0] opcode;
    logic       r_ok;
    logic       i_ok;

    always_comb begin
        funct = '0;
        r_ok  = 1'b0;
        case (alu_op)
            ALU_ADD: begin funct = FN_ADD; r_ok = 1'b1; end
            ALU_SUB: begin funct = FN_SUB; r_ok = 1'b1; end
            ALU_AND: begin funct = FN_AND; r_ok = 1'b1; end
            ALU_OR:  begin funct = FN_OR;  r_ok = 1'b1; end
            ALU_NOR: begin funct = FN_NOR; r_ok = 1'b1; end
            ALU_XOR: begin funct = FN_XOR; r_ok = 1'b1; end
            default: ;
        endcase
    end

    // Only ADD takes a sign-extended immediate; logic ops zero-extend.
    always_comb begin
        opcode = '0;
        i_ok   = 1'b0;
        case (alu_op)
            ALU_ADD: begin
                opcode = OP_ADDI;
                i_ok   = (alu_src2 == SRC2_SEXT);
            end
            ALU_AND: begin
                opcode = OP_ANDI;
                i_ok   = (alu_src2 == SRC2_ZEXT);
            end
            ALU_OR: begin
                opcode = OP_ORI;
                i_ok   = (alu_src2 == SRC2_ZEXT);
            end
            ALU_XOR: begin
                opcode = OP_XORI;
                i_ok   = (alu_src2 == SRC2_ZEXT);
            end
            default: ;
        endcase
    end

    always_comb begin
        inst   = '0;
        except = 1'b1;
        if (!rd_src && alu_src2 == SRC2_REG && r_ok) begin
            inst   = {OP_RTYPE, rs, rt, rd, 5'h00, funct};
            except = 1'b0;
        end else if (rd_src && i_ok) begin
            inst   = {opcode, rs, rt, imm};
            except = 1'b0;
        end
    end

endmodule

// File: rtl/mips_encode.sv
// MIPS instruction encoder: encodes requests into a 2-entry FIFO
// and counts emitted valid instructions.
module mips_encode
    import mips_encode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  alu_op,
    input  logic [1:0]  alu_src2,
    input  logic        rd_src,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        except,
    output logic [15:0] inst_count
);

    enc_t        enc;
    enc_t        head;
    enc_t        mem_q [2];
    enc_t        mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] cnt_q, cnt_d;
    logic        push;
    logic        pop;

    mips_encode_fields u_fields (
        .alu_op   (alu_op),
        .alu_src2 (alu_src2),
        .rd_src   (rd_src),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .imm      (imm),
        .inst     (enc.inst),
        .except   (enc.except)
    );

    // Gating with reset keeps in_ready low while reset is held.
    assign in_ready  = (count_q != 2'd2) && !reset;
    assign out_valid = (count_q != 2'd0);
    assign head      = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign inst       = out_valid ? head.inst : 32'h0;
    assign except     = out_valid && head.except;
    assign inst_count = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = enc;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
            if (!head.except) begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            cnt_q    <= 16'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mips_encode.sv
// Scoreboard bench for mips_encode: random and directed requests
// checked against a reference encoder and an output monitor.
module tb_mips_encode;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op = '0;
    logic [1:0]  alu_src2 = '0;
    logic        rd_src = 1'b0;
    logic [4:0]  rs = '0;
    logic [4:0]  rt = '0;
    logic [4:0]  rd = '0;
    logic [15:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] inst;
    logic        except;
    logic [15:0] inst_count;

    int          checks = 0;
    int          passed = 0;
    int          rdy_mode = 0;
    logic [32:0] sb [$];
    logic [15:0] exp_count = '0;

    mips_encode dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .alu_src2   (alu_src2),
        .rd_src     (rd_src),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .inst       (inst),
        .except     (except),
        .inst_count (inst_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Reference encoder: {except, inst}, built from field positions.
    function automatic logic [32:0] ref_enc(input logic [2:0] op,
            input logic [1:0] s2, input logic rds, input logic [4:0] a,
            input logic [4:0] b, input logic [4:0] c, input logic [15:0] im);
        int fn [8] = '{0, 0, 32'h20, 32'h22, 32'h24, 32'h25, 32'h27, 32'h26};
        int opc = -1;
        logic [31:0] w;
        if (!rds && s2 == 2'd0 && op >= 3'd2) begin
            w = ({27'd0, a} << 21) | ({27'd0, b} << 16) | ({27'd0, c} << 11)
                | fn[op];
            return {1'b0, w};
        end
        if (rds) begin
            if (op == 3'd2 && s2 == 2'd1) opc = 8;
            else if (op == 3'd4 && s2 == 2'd2) opc = 12;
            else if (op == 3'd5 && s2 == 2'd2) opc = 13;
            else if (op == 3'd7 && s2 == 2'd2) opc = 14;
        end
        if (opc >= 0) begin
            w = (opc << 26) | ({27'd0, a} << 21) | ({27'd0, b} << 16)
                | {16'd0, im};
            return {1'b0, w};
        end
        return {1'b1, 32'd0};
    endfunction

    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Output monitor: pops the scoreboard on each handshake.
    logic        stall = 1'b0;
    logic [32:0] held = '0;
    initial forever begin
        logic [32:0] e;
        @(negedge clock);
        if (reset) begin
            stall = 1'b0;
            continue;
        end
        check("inst_count", inst_count, exp_count);
        if (stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_inst", inst, held[31:0]);
            check("hold_except", except, held[32]);
        end
        if (!out_valid) begin
            check("idle_inst", inst, 0);
            check("idle_except", except, 0);
        end
        stall = out_valid && !out_ready;
        held  = {except, inst};
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pop_inst", inst, e[31:0]);
                check("pop_except", except, e[32]);
                if (!e[32]) exp_count++;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] s2,
            input logic rds, input logic [4:0] a, input logic [4:0] b,
            input logic [4:0] c, input logic [15:0] im);
        bit ok = 0;
        alu_op = op; alu_src2 = s2; rd_src = rds;
        rs = a; rt = b; rd = c; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (in_ready) begin
                sb.push_back(ref_enc(op, s2, rds, a, b, c, im));
                ok = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        rdy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clock);
            #2;
            if (sb.size() == 0 && !out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 0, 1);
    endtask

    task automatic stall_out();
        rdy_mode = 0;
        @(posedge clock);
        #2;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_inst", inst, 0);
        check("rst_except", except, 0);
        check("rst_count", inst_count, 0);
        #2 reset = 1'b0;
        #1 check("post_rst_ready", in_ready, 1);

        stall_out();
        send(3'd2, 2'd0, 1'b0, 5'd1, 5'd2, 5'd3, 16'h1234);
        check("lat_valid", out_valid, 1);
        check("r_add_inst", inst, 32'h00221820);
        check("r_add_except", except, 0);
        drain();
        check("count_r_add", inst_count, 1);

        stall_out();
        send(3'd2, 2'd1, 1'b1, 5'd4, 5'd5, 5'd9, 16'hFFFF);
        check("addi_inst", inst, 32'h2085FFFF);
        drain();
        stall_out();
        send(3'd7, 2'd2, 1'b1, 5'd4, 5'd5, 5'd9, 16'hFFFF);
        check("xori_inst", inst, 32'h3885FFFF);
        drain();
        check("count_i", inst_count, 3);

        stall_out();
        send(3'd2, 2'd0, 1'b1, 5'd4, 5'd5, 5'd9, 16'h00FF);
        check("bad_inst", inst, 0);
        check("bad_except", except, 1);
        drain();
        check("count_bad", inst_count, 3);

        stall_out();
        send(3'd3, 2'd0, 1'b0, 5'd7, 5'd8, 5'd9, 16'h0);
        send(3'd5, 2'd2, 1'b1, 5'd10, 5'd11, 5'd0, 16'hABCD);
        alu_op = 3'd6; alu_src2 = 2'd0; rd_src = 1'b0;
        in_valid = 1'b1;
        @(negedge clock);
        check("full_ready", in_ready, 0);
        rdy_mode = 1;
        send(3'd6, 2'd0, 1'b0, 5'd12, 5'd13, 5'd14, 16'h0);
        drain();

        rdy_mode = 2;
        for (int n = 0; n < 400; n++) begin
            send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                 5'($urandom), 16'($urandom));
        end
        drain();

        stall_out();
        send(3'd4, 2'd0, 1'b0, 5'd1, 5'd1, 5'd1, 16'h0);
        send(3'd2, 2'd1, 1'b1, 5'd2, 5'd2, 5'd2, 16'h8000);
        @(posedge clock);
        #3 reset = 1'b1;
        sb.delete();
        exp_count = '0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", inst_count, 0);
        check("arst_ready", in_ready, 0);
        check("arst_inst", inst, 0);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 check("rel_ready", in_ready, 1);
        rdy_mode = 1;
        repeat (5) @(posedge clock);
        #1;
        check("rel_valid", out_valid, 0);
        check("rel_count", inst_count, 0);

        rdy_mode = 1;
        for (int n = 0; n < 65535; n++) begin
            send(3'($urandom_range(2, 7)), 2'd0, 1'b0, 5'($urandom),
                 5'($urandom), 5'($urandom), 16'h0);
        end
        drain();
        check("count_ffff", inst_count, 32'h0000FFFF);
        send(3'd2, 2'd1, 1'b1, 5'd3, 5'd3, 5'd3, 16'h0001);
        drain();
        check("count_wrap", inst_count, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
